// File: rtl/delay_tap_scheduler.sv
// Single-port delay-line RAM scheduler: per-frame tap reads, one sample write, idle-time aux access.
// Optional build macro DELAY_DECIM_EN: advance the write pointer only on every second frame.
module delay_tap_scheduler #(
   parameter int unsigned ADDR_W = 13,
   parameter int unsigned DATA_W = 11,
   parameter int unsigned NTAPS  = 4,
   // NTAPS=1 would give a zero-width index, so keep at least one bit
   localparam int unsigned IDX_W = (NTAPS > 1) ? $clog2(NTAPS) : 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    frame_start,
   input  logic [DATA_W-1:0]       wr_data,
   input  logic [NTAPS-1:0]        tap_en,
   input  logic [NTAPS*ADDR_W-1:0] tap_offset,
   output logic                    tap_valid,
   output logic [IDX_W-1:0]        tap_idx,
   output logic [DATA_W-1:0]       tap_data,
   output logic                    frame_done,
   output logic                    overrun,
   input  logic                    aux_req,
   input  logic                    aux_we,
   input  logic [ADDR_W-1:0]       aux_addr,
   input  logic [DATA_W-1:0]       aux_wdata,
   output logic                    aux_gnt,
   output logic                    aux_rvalid,
   output logic [ADDR_W-1:0]       ram_addr,
   output logic                    ram_we,
   output logic [DATA_W-1:0]       ram_wdata,
   input  logic [DATA_W-1:0]       ram_rdata
);

   typedef enum logic [1:0] {
      StIdle,
      StRead,
      StDrain,
      StWrite
   } state_e;

   state_e                  state;
   logic [IDX_W-1:0]        slot;
   logic [ADDR_W-1:0]       wr_ptr;
   logic [DATA_W-1:0]       wdata_held;
   logic [NTAPS-1:0]        en_held;
   logic [NTAPS*ADDR_W-1:0] off_held;
`ifdef DELAY_DECIM_EN
   logic                    decim_tgl;
`endif

   logic [ADDR_W-1:0] off_arr [NTAPS];
   logic [IDX_W-1:0]  slot_next;
   logic [ADDR_W-1:0] rd_addr_next;
   logic              last_slot;

   // Read data is never registered here; the tap and aux consumers see the RAM port directly.
   assign tap_data = ram_rdata;

   always_comb begin
      for (int i = 0; i < int'(NTAPS); i++) begin
         off_arr[i] = off_held[i*ADDR_W +: ADDR_W];
      end
   end

   always_comb begin
      slot_next    = slot + IDX_W'(1);
      last_slot    = (slot == IDX_W'(NTAPS - 1));
      rd_addr_next = wr_ptr;
      if (32'(slot_next) < NTAPS) begin
         rd_addr_next = wr_ptr - off_arr[slot_next];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= StIdle;
         slot       <= '0;
         wr_ptr     <= '0;
         wdata_held <= '0;
         en_held    <= '0;
         off_held   <= '0;
`ifdef DELAY_DECIM_EN
         decim_tgl  <= 1'b0;
`endif
         tap_valid  <= 1'b0;
         tap_idx    <= '0;
         frame_done <= 1'b0;
         overrun    <= 1'b0;
         aux_gnt    <= 1'b0;
         aux_rvalid <= 1'b0;
         ram_addr   <= '0;
         ram_we     <= 1'b0;
         ram_wdata  <= '0;
      end else begin
         // RAM port idles at address 0 / read unless an access is issued below
         ram_addr   <= '0;
         ram_we     <= 1'b0;
         ram_wdata  <= '0;
         tap_valid  <= 1'b0;
         frame_done <= 1'b0;
         aux_gnt    <= 1'b0;
         aux_rvalid <= aux_gnt & ~ram_we;

         if (frame_start && (state != StIdle)) begin
            overrun <= 1'b1;
         end

         unique case (state)
            StIdle: begin
               if (frame_start) begin
                  wdata_held <= wr_data;
                  en_held    <= tap_en;
                  off_held   <= tap_offset;
                  slot       <= '0;
                  ram_addr   <= wr_ptr - tap_offset[ADDR_W-1:0];
                  state      <= StRead;
               end else if (aux_req) begin
                  ram_addr  <= aux_addr;
                  ram_we    <= aux_we;
                  ram_wdata <= aux_wdata;
                  aux_gnt   <= 1'b1;
               end
            end
            StRead: begin
               // Data for this slot's address lands on the RAM port one cycle later
               tap_valid <= en_held[slot];
               tap_idx   <= slot;
               if (last_slot) begin
                  state <= StDrain;
               end else begin
                  slot     <= slot_next;
                  ram_addr <= rd_addr_next;
               end
            end
            StDrain: begin
               ram_addr  <= wr_ptr;
               ram_we    <= 1'b1;
               ram_wdata <= wdata_held;
               state     <= StWrite;
            end
            StWrite: begin
`ifdef DELAY_DECIM_EN
               if (decim_tgl) begin
                  wr_ptr <= wr_ptr + ADDR_W'(1);
               end
               decim_tgl <= ~decim_tgl;
`else
               wr_ptr <= wr_ptr + ADDR_W'(1);
`endif
               frame_done <= 1'b1;
               state      <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_delay_tap_scheduler.sv
// Directed self-checking bench for delay_tap_scheduler with a behavioural synchronous RAM.
// Expectations follow the DELAY_DECIM_EN build setting when it is defined.
module tb_delay_tap_scheduler;

   localparam int AW = 13;
   localparam int DW = 11;
   localparam int NT = 4;
`ifdef DELAY_DECIM_EN
   localparam int DECIM = 1;
`else
   localparam int DECIM = 0;
`endif

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 frame_start;
   logic [DW-1:0]        wr_data;
   logic [NT-1:0]        tap_en;
   logic [NT*AW-1:0]     tap_offset;
   logic                 tap_valid;
   logic [$clog2(NT)-1:0] tap_idx;
   logic [DW-1:0]        tap_data;
   logic                 frame_done;
   logic                 overrun;
   logic                 aux_req;
   logic                 aux_we;
   logic [AW-1:0]        aux_addr;
   logic [DW-1:0]        aux_wdata;
   logic                 aux_gnt;
   logic                 aux_rvalid;
   logic [AW-1:0]        ram_addr;
   logic                 ram_we;
   logic [DW-1:0]        ram_wdata;
   logic [DW-1:0]        ram_rdata;

   int checks = 0;
   int failures = 0;

   logic [DW-1:0] mem [2**AW];

   // Per-cycle capture of one frame, indexed by cycle number after frame_start
   logic [AW-1:0] c_addr  [16];
   logic          c_we    [16];
   logic [DW-1:0] c_wdata [16];
   logic          c_tv    [16];
   logic [1:0]    c_idx   [16];
   logic [DW-1:0] c_data  [16];
   logic          c_fd    [16];

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   delay_tap_scheduler dut (
      .clk        (clk),
      .reset      (reset),
      .frame_start(frame_start),
      .wr_data    (wr_data),
      .tap_en     (tap_en),
      .tap_offset (tap_offset),
      .tap_valid  (tap_valid),
      .tap_idx    (tap_idx),
      .tap_data   (tap_data),
      .frame_done (frame_done),
      .overrun    (overrun),
      .aux_req    (aux_req),
      .aux_we     (aux_we),
      .aux_addr   (aux_addr),
      .aux_wdata  (aux_wdata),
      .aux_gnt    (aux_gnt),
      .aux_rvalid (aux_rvalid),
      .ram_addr   (ram_addr),
      .ram_we     (ram_we),
      .ram_wdata  (ram_wdata),
      .ram_rdata  (ram_rdata)
   );

   task automatic do_reset();
      reset = 1'b1;
      frame_start = 1'b0;
      aux_req = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   // Starts a frame in the current cycle (cycle 0) and captures cycles 1..NT+3.
   task automatic run_frame(input logic [DW-1:0] wd, input logic [NT-1:0] en,
                            input logic [NT*AW-1:0] off, input int extra_fs);
      frame_start = 1'b1;
      wr_data     = wd;
      tap_en      = en;
      tap_offset  = off;
      for (int k = 1; k <= NT + 3; k++) begin
         @(posedge clk);
         #1;
         frame_start = (k == extra_fs);
         c_addr[k]  = ram_addr;
         c_we[k]    = ram_we;
         c_wdata[k] = ram_wdata;
         c_tv[k]    = tap_valid;
         c_idx[k]   = tap_idx;
         c_data[k]  = tap_data;
         c_fd[k]    = frame_done;
      end
      frame_start = 1'b0;
   endtask

   task automatic test_reset();
      logic [7:0] outs;
      reset = 1'b1;
      #1;
      outs = {tap_valid, frame_done, overrun, aux_gnt, aux_rvalid, ram_we, (ram_addr != 0),
              (tap_idx != 0)};
      checks++;
      if (outs !== 8'h00) begin
         failures++;
         $display("FAIL reset_outputs: got %b want 00000000", outs);
      end
      do_reset();
      // Mid-frame reset: asynchronous abort, and no write afterwards
      run_frame(11'h7F, 4'b1111, '0, 0);
      frame_start = 1'b1;
      wr_data = 11'h3C;
      @(posedge clk);
      #1 frame_start = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;
      #1;
      checks++;
      if ({tap_valid, ram_addr} !== '0) begin
         failures++;
         $display("FAIL async_reset_abort: got tv=%b addr=%0d want 0/0", tap_valid, ram_addr);
      end
      @(posedge clk);
      #1 reset = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk);
         #1;
         checks++;
         if (ram_we !== 1'b0) begin
            failures++;
            $display("FAIL no_write_after_abort: cycle %0d got we=%b want 0", k, ram_we);
         end
      end
   endtask

   task automatic test_basic_frames();
      logic [DW-1:0] wds [3];
      int exp_ptr;
      wds[0] = 11'd5;
      wds[1] = 11'd6;
      wds[2] = 11'd7;
      do_reset();
      for (int f = 0; f < 3; f++) begin
         exp_ptr = DECIM ? f / 2 : f;
         run_frame(wds[f], 4'b0001, {13'd0, 13'd0, 13'd0, 13'd1}, 0);
         checks++;
         if (c_addr[1] !== AW'(exp_ptr - 1) || c_we[1] !== 1'b0) begin
            failures++;
            $display("FAIL basic_read_addr f%0d: got %0d we=%b want %0d we=0", f, c_addr[1],
                     c_we[1], AW'(exp_ptr - 1));
         end
         checks++;
         if (c_we[6] !== 1'b1 || c_addr[6] !== AW'(exp_ptr) || c_wdata[6] !== wds[f]) begin
            failures++;
            $display("FAIL basic_write f%0d: got we=%b addr=%0d data=%0d want 1/%0d/%0d", f,
                     c_we[6], c_addr[6], c_wdata[6], exp_ptr, wds[f]);
         end
      end
      checks++;
      if (c_tv[2] !== 1'b1 || c_idx[2] !== 2'd0 || c_data[2] !== 11'd6) begin
         failures++;
         $display("FAIL basic_tap0: got tv=%b idx=%0d data=%0d want 1/0/6", c_tv[2], c_idx[2],
                  c_data[2]);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      run_frame(11'd3, 4'b0001, {13'd0, 13'd0, 13'd0, 13'd3}, 0);
      checks++;
      if (c_addr[1] !== 13'h1FFD) begin
         failures++;
         $display("FAIL wrap_read_addr: got %0h want 1ffd", c_addr[1]);
      end
      checks++;
      if (c_addr[2] !== 13'd0) begin
         failures++;
         $display("FAIL offset0_addr: got %0d want 0", c_addr[2]);
      end
`ifndef DELAY_DECIM_EN
      for (int k = 1; k < 8192; k++) begin
         run_frame(DW'(k + 3), '0, '0, 0);
      end
      run_frame(11'h400, 4'b0011, {13'd0, 13'd0, 13'd1, 13'd0}, 0);
      checks++;
      if (c_we[6] !== 1'b1 || c_addr[6] !== 13'd0) begin
         failures++;
         $display("FAIL wrap_write_addr: got we=%b addr=%0d want 1/0", c_we[6], c_addr[6]);
      end
      checks++;
      if (c_tv[2] !== 1'b1 || c_data[2] !== 11'd3) begin
         failures++;
         $display("FAIL offset0_oldest: got tv=%b data=%0d want 1/3", c_tv[2], c_data[2]);
      end
      checks++;
      if (c_tv[3] !== 1'b1 || c_data[3] !== 11'd2) begin
         failures++;
         $display("FAIL offset1_prev: got tv=%b data=%0d want 1/2", c_tv[3], c_data[3]);
      end
`endif
   endtask

   task automatic test_tap_enable();
      logic exp_tv;
      do_reset();
      run_frame(11'd9, 4'b1010, {13'd4, 13'd3, 13'd2, 13'd1}, 0);
      for (int k = 1; k <= NT + 3; k++) begin
         exp_tv = (k == 3) || (k == 5);
         checks++;
         if (c_tv[k] !== exp_tv || c_fd[k] !== (k == 7)) begin
            failures++;
            $display("FAIL tap_en_pattern c%0d: got tv=%b fd=%b want %b/%b", k, c_tv[k],
                     c_fd[k], exp_tv, (k == 7));
         end
      end
      checks++;
      if (c_idx[3] !== 2'd1 || c_idx[5] !== 2'd3) begin
         failures++;
         $display("FAIL tap_idx: got %0d,%0d want 1,3", c_idx[3], c_idx[5]);
      end
   endtask

   task automatic test_overrun();
      int nwr;
      do_reset();
      checks++;
      if (overrun !== 1'b0) begin
         failures++;
         $display("FAIL overrun_initial: got %b want 0", overrun);
      end
      run_frame(11'h11, 4'b0000, '0, 3);
      nwr = 0;
      for (int k = 1; k <= NT + 3; k++) nwr += int'(c_we[k]);
      checks++;
      if (overrun !== 1'b1 || nwr != 1 || c_fd[7] !== 1'b1) begin
         failures++;
         $display("FAIL overrun_frame: got ovr=%b writes=%0d fd7=%b want 1/1/1", overrun, nwr,
                  c_fd[7]);
      end
      // Back-to-back: frame_start on cycle 7 must be accepted
      run_frame(11'h22, 4'b0001, {13'd0, 13'd0, 13'd0, 13'd2}, 0);
      checks++;
      if (c_we[1] !== 1'b0 || c_addr[1] !== (DECIM ? 13'd8190 : 13'd8191)) begin
         failures++;
         $display("FAIL back_to_back_read: got we=%b addr=%0d", c_we[1], c_addr[1]);
      end
      checks++;
      if (c_we[6] !== 1'b1 || c_addr[6] !== (DECIM ? 13'd0 : 13'd1) || c_wdata[6] !== 11'h22) begin
         failures++;
         $display("FAIL back_to_back_write: got we=%b addr=%0d data=%0h", c_we[6], c_addr[6],
                  c_wdata[6]);
      end
      checks++;
      if (overrun !== 1'b1) begin
         failures++;
         $display("FAIL overrun_sticky: got %b want 1", overrun);
      end
   endtask

   task automatic test_aux();
      int gcyc;
      int fdcyc;
      do_reset();
      aux_req = 1'b1;
      aux_we = 1'b1;
      aux_addr = 13'h10;
      aux_wdata = 11'h2AB;
      @(posedge clk);
      #1;
      checks++;
      if (aux_gnt !== 1'b1 || ram_addr !== 13'h10 || ram_we !== 1'b1 || ram_wdata !== 11'h2AB) begin
         failures++;
         $display("FAIL aux_write_grant: got gnt=%b addr=%0h we=%b data=%0h want 1/10/1/2ab",
                  aux_gnt, ram_addr, ram_we, ram_wdata);
      end
      aux_req = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (aux_gnt !== 1'b0 || aux_rvalid !== 1'b0) begin
         failures++;
         $display("FAIL aux_write_after: got gnt=%b rvalid=%b want 0/0", aux_gnt, aux_rvalid);
      end
      // Aux read colliding with frame_start: frame wins, grant follows frame_done
      frame_start = 1'b1;
      wr_data = 11'h55;
      tap_en = '0;
      tap_offset = '0;
      aux_req = 1'b1;
      aux_we = 1'b0;
      gcyc = -1;
      fdcyc = -1;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk);
         #1;
         frame_start = 1'b0;
         if (frame_done === 1'b1 && fdcyc < 0) fdcyc = k;
         if (gcyc >= 0 && k == gcyc + 1) begin
            checks++;
            if (aux_rvalid !== 1'b1 || tap_data !== 11'h2AB || tap_valid !== 1'b0) begin
               failures++;
               $display("FAIL aux_rvalid: got rv=%b data=%0h tv=%b want 1/2ab/0", aux_rvalid,
                        tap_data, tap_valid);
            end
         end
         if (aux_gnt === 1'b1 && gcyc < 0) begin
            gcyc = k;
            aux_req = 1'b0;
            checks++;
            if (ram_addr !== 13'h10 || ram_we !== 1'b0) begin
               failures++;
               $display("FAIL aux_read_grant: got addr=%0h we=%b want 10/0", ram_addr, ram_we);
            end
         end
      end
      aux_req = 1'b0;
      checks++;
      if (gcyc != 8 || fdcyc != 7) begin
         failures++;
         $display("FAIL aux_deferred: got grant=%0d done=%0d want 8/7", gcyc, fdcyc);
      end
      // Held request yields back-to-back grants
      aux_req = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (aux_gnt !== 1'b1) begin
         failures++;
         $display("FAIL aux_b2b_first: got gnt=%b want 1", aux_gnt);
      end
      @(posedge clk);
      #1;
      checks++;
      if (aux_gnt !== 1'b1 || aux_rvalid !== 1'b1 || tap_data !== 11'h2AB) begin
         failures++;
         $display("FAIL aux_b2b_second: got gnt=%b rv=%b data=%0h want 1/1/2ab", aux_gnt,
                  aux_rvalid, tap_data);
      end
      aux_req = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (aux_gnt !== 1'b0 || aux_rvalid !== 1'b1) begin
         failures++;
         $display("FAIL aux_b2b_end: got gnt=%b rv=%b want 0/1", aux_gnt, aux_rvalid);
      end
   endtask

   task automatic test_write_advance();
      int exp_addr;
      do_reset();
      for (int f = 0; f < 4; f++) begin
         exp_addr = DECIM ? f / 2 : f;
         run_frame(DW'(f + 40), '0, '0, 0);
         checks++;
         if (c_we[6] !== 1'b1 || c_addr[6] !== AW'(exp_addr)) begin
            failures++;
            $display("FAIL write_advance f%0d: got we=%b addr=%0d want 1/%0d", f, c_we[6],
                     c_addr[6], exp_addr);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 2**AW; i++) mem[i] = '0;
      frame_start = 1'b0;
      wr_data = '0;
      tap_en = '0;
      tap_offset = '0;
      aux_req = 1'b0;
      aux_we = 1'b0;
      aux_addr = '0;
      aux_wdata = '0;
      test_reset();
      test_basic_frames();
      test_wrap();
      test_tap_enable();
      test_overrun();
      test_aux();
      test_write_advance();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
